// File: rtl/display_480p_pkg.sv
// Timing constants for the 640x480 @ 60 Hz VGA raster (25 MHz pixel rate).
`timescale 1ns/1ps
package display_480p_pkg;

    localparam int H_RES   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;

    localparam int V_RES   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows and last counter values
    localparam int H_SYNC_START = H_RES + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int H_MAX        = H_TOTAL - 1;

    localparam int V_SYNC_START = V_RES + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int V_MAX        = V_TOTAL - 1;

endpackage

// File: rtl/display_480p_clkdiv.sv
// Divide-by-2 of the system clock: a 25 MHz pixel clock plus the matching
// advance strobe, which is high on the clk edge where clk_pixel falls.
`timescale 1ns/1ps
module display_480p_clkdiv (
    input  logic clk,
    input  logic rst,
    output logic clk_pixel,
    output logic pix_stb
);

    logic pix_q;
    logic pix_d;

    assign pix_d = ~pix_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign clk_pixel = pix_q;
    assign pix_stb   = pix_q;

endmodule

// File: rtl/display_480p.sv
// 640x480 @ 60 Hz VGA timing generator: pixel coordinates, syncs, data enable.
// Define DISPLAY_480P_STROBE_EN to add the registered line/frame strobe outputs.
`timescale 1ns/1ps
module display_480p
    import display_480p_pkg::*;
#(
    parameter int CORDW = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clk_pixel,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             data_en
`ifdef DISPLAY_480P_STROBE_EN
    ,
    output logic             line,
    output logic             frame
`endif
);

    logic             pix_stb;
    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;

    display_480p_clkdiv u_clkdiv (
        .clk       (clk),
        .rst       (rst),
        .clk_pixel (clk_pixel),
        .pix_stb   (pix_stb)
    );

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (pix_stb) begin
            if (sx_q == CORDW'(H_MAX)) begin
                sx_d = '0;
                sy_d = (sy_q == CORDW'(V_MAX)) ? '0 : sy_q + CORDW'(1);
            end else begin
                sx_d = sx_q + CORDW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    assign sx = sx_q;
    assign sy = sy_q;

    // Zero-latency decodes straight off the registered coordinates
    assign hsync   = !((sx_q >= CORDW'(H_SYNC_START)) && (sx_q <= CORDW'(H_SYNC_END)));
    assign vsync   = !((sy_q >= CORDW'(V_SYNC_START)) && (sy_q <= CORDW'(V_SYNC_END)));
    assign data_en = (sx_q <= CORDW'(H_RES - 1)) && (sy_q <= CORDW'(V_RES - 1));

`ifdef DISPLAY_480P_STROBE_EN
    logic line_q, frame_q;

    // Registered from next-state so the pulses line up with sx/sy themselves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            line_q  <= (sx_d == '0);
            frame_q <= (sx_d == '0) && (sy_d == '0);
        end
    end

    assign line  = line_q;
    assign frame = frame_q;
`endif

endmodule

// File: tb/tb_display_480p.sv
// Directed bench for display_480p: reset, horizontal/vertical decode, wraps,
// line period and asynchronous mid-frame reset.
`timescale 1ns/1ps
module tb_display_480p;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_pixel;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hsync;
    logic       vsync;
    logic       data_en;
`ifdef DISPLAY_480P_STROBE_EN
    logic       line;
    logic       frame;
`endif

    int passCount  = 0;
    int totalCount = 0;

    display_480p #(.CORDW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_pixel (clk_pixel),
        .sx        (sx),
        .sy        (sy),
        .hsync     (hsync),
        .vsync     (vsync),
        .data_en   (data_en)
`ifdef DISPLAY_480P_STROBE_EN
        ,
        .line      (line),
        .frame     (frame)
`endif
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Preload the counters on a non-advancing edge; returns at a negedge with
    // clk_pixel high, so the next rising clk edge advances from (x, y).
    task automatic jumpTo(input int x, input int y);
        @(negedge clk);
        while (clk_pixel !== 1'b0) @(negedge clk);
        force dut.sx_q = 10'(x);
        force dut.sy_q = 10'(y);
        @(posedge clk);
        @(negedge clk);
        release dut.sx_q;
        release dut.sy_q;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #100;
        @(negedge clk);
        totalCount++;
        if ({clk_pixel, sx, sy, hsync, vsync, data_en} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1})
            $display("[TB] FAIL reset_values: got clk_pixel=%0b sx=%0d sy=%0d hs=%0b vs=%0b de=%0b, want 0 0 0 1 1 1",
                     clk_pixel, sx, sy, hsync, vsync, data_en);
        else passCount++;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            totalCount++;
            if ({clk_pixel, sx, sy} !== {1'(k % 2), 10'(k / 2), 10'd0})
                $display("[TB] FAIL post_reset_edge%0d: got clk_pixel=%0b sx=%0d sy=%0d, want %0d %0d 0",
                         k, clk_pixel, sx, sy, k % 2, k / 2);
            else passCount++;
        end
    endtask

    task automatic test_horizontal();
        int hsLow = 0, hsFirst = -1, hsLast = -1, deFall = -1, wrapSy = -1, wrapPrevSy = -1;
        int outOfRange = 0;
        bit wrapped = 0;
        logic [9:0] prevSx = sx, prevSy = sy;
        logic prevDe = data_en;
        for (int c = 0; c < 1700 && !wrapped; c++) begin
            step();
            if (sx > 10'd799 || sy > 10'd524) outOfRange++;
            if (!hsync) begin
                hsLow++;
                if (hsFirst < 0) hsFirst = int'(sx);
                hsLast = int'(sx);
            end
            if (prevDe && !data_en && deFall < 0) deFall = int'(sx);
            if (prevSx == 10'd799 && sx == 10'd0) begin
                wrapped    = 1;
                wrapSy     = int'(sy);
                wrapPrevSy = int'(prevSy);
            end
            prevSx = sx;
            prevSy = sy;
            prevDe = data_en;
        end
        totalCount++;
        if (!wrapped) $display("[TB] FAIL h_wrap_seen: got no 799->0 wrap, want one within 1700 cycles");
        else passCount++;
        totalCount++;
        if (deFall !== 640) $display("[TB] FAIL h_de_fall: got sx=%0d, want 640", deFall);
        else passCount++;
        totalCount++;
        if (hsFirst !== 656 || hsLast !== 751)
            $display("[TB] FAIL h_sync_window: got %0d..%0d, want 656..751", hsFirst, hsLast);
        else passCount++;
        totalCount++;
        if (hsLow !== 192) $display("[TB] FAIL h_sync_cycles: got %0d, want 192", hsLow);
        else passCount++;
        totalCount++;
        if (wrapPrevSy !== 0 || wrapSy !== 1)
            $display("[TB] FAIL h_wrap_sy: got sy %0d->%0d, want 0->1", wrapPrevSy, wrapSy);
        else passCount++;
        totalCount++;
        if (outOfRange !== 0) $display("[TB] FAIL h_range: got %0d out-of-range samples, want 0", outOfRange);
        else passCount++;
    endtask

    task automatic test_line_period();
        int period = -1;
        logic [9:0] prevSx = sx;
        for (int c = 1; c <= 1700 && period < 0; c++) begin
            step();
            if (prevSx == 10'd799 && sx == 10'd0) period = c;
            prevSx = sx;
        end
        totalCount++;
        if (period !== 1600) $display("[TB] FAIL line_period: got %0d cycles, want 1600", period);
        else passCount++;
    endtask

    task automatic test_vertical_active();
        int deHigh479 = 0, deBad = 0, line480 = 0;
        bit done = 0;
        logic [9:0] prevSy;
        jumpTo(630, 479);
        prevSy = sy;
        for (int c = 0; c < 3400 && !done; c++) begin
            step();
            if (sy == 10'd479 && data_en) deHigh479++;
            if (sy >= 10'd480 && data_en) deBad++;
            if (sy == 10'd480) line480++;
            if (prevSy == 10'd480 && sy == 10'd481) done = 1;
            prevSy = sy;
        end
        totalCount++;
        if (deHigh479 !== 18) $display("[TB] FAIL v_de_tail479: got %0d cycles, want 18", deHigh479);
        else passCount++;
        totalCount++;
        if (!done || line480 !== 1600)
            $display("[TB] FAIL v_line480_len: got %0d cycles (done=%0b), want 1600", line480, done);
        else passCount++;
        totalCount++;
        if (deBad !== 0) $display("[TB] FAIL v_de_blank: got %0d high cycles at sy>=480, want 0", deBad);
        else passCount++;
    endtask

    task automatic test_vsync();
        int vsLow = 0, vsFirst = -1, vsLast = -1, vsFirstSx = -1, deBad = 0;
        bit done = 0;
        logic [9:0] prevSy;
        jumpTo(790, 489);
        prevSy = sy;
        for (int c = 0; c < 3500 && !done; c++) begin
            step();
            if (!vsync) begin
                vsLow++;
                if (vsFirst < 0) begin
                    vsFirst   = int'(sy);
                    vsFirstSx = int'(sx);
                end
                vsLast = int'(sy);
            end
            if (data_en) deBad++;
            if (prevSy == 10'd491 && sy == 10'd492) done = 1;
            prevSy = sy;
        end
        totalCount++;
        if (!done || vsLow !== 3200)
            $display("[TB] FAIL v_sync_cycles: got %0d (done=%0b), want 3200", vsLow, done);
        else passCount++;
        totalCount++;
        if (vsFirst !== 490 || vsLast !== 491 || vsFirstSx !== 0)
            $display("[TB] FAIL v_sync_window: got sy %0d..%0d from sx=%0d, want 490..491 from sx=0",
                     vsFirst, vsLast, vsFirstSx);
        else passCount++;
        totalCount++;
        if (deBad !== 0) $display("[TB] FAIL v_sync_de: got %0d high cycles, want 0", deBad);
        else passCount++;
    endtask

    task automatic test_frame_wrap();
        int cycles = -1;
        logic [9:0] prevSx, prevSy;
        jumpTo(797, 524);
        prevSx = sx;
        prevSy = sy;
        for (int c = 1; c <= 20 && cycles < 0; c++) begin
            step();
            if (sx == 10'd0 && sy == 10'd0) cycles = c;
            else begin
                prevSx = sx;
                prevSy = sy;
            end
        end
        totalCount++;
        if (cycles !== 5 || prevSx !== 10'd799 || prevSy !== 10'd524)
            $display("[TB] FAIL frame_wrap: got %0d cycles from (%0d,%0d), want 5 from (799,524)",
                     cycles, prevSx, prevSy);
        else passCount++;
        totalCount++;
        if ({hsync, vsync, data_en} !== 3'b111)
            $display("[TB] FAIL frame_origin_decode: got hs/vs/de=%0b%0b%0b, want 111", hsync, vsync, data_en);
        else passCount++;
`ifdef DISPLAY_480P_STROBE_EN
        totalCount++;
        if ({line, frame} !== 2'b11)
            $display("[TB] FAIL frame_strobes: got line=%0b frame=%0b, want 1 1", line, frame);
        else passCount++;
`endif
    endtask

    task automatic test_mid_reset();
        jumpTo(300, 200);
        step();
        step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        totalCount++;
        if ({clk_pixel, sx, sy, hsync, vsync, data_en} !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1})
            $display("[TB] FAIL mid_reset_async: got clk_pixel=%0b sx=%0d sy=%0d hs=%0b vs=%0b de=%0b, want 0 0 0 1 1 1",
                     clk_pixel, sx, sy, hsync, vsync, data_en);
        else passCount++;
        @(negedge clk);
        rst = 1'b0;
        step();
        totalCount++;
        if ({clk_pixel, sx, sy} !== {1'b1, 10'd0, 10'd0})
            $display("[TB] FAIL mid_reset_edge1: got clk_pixel=%0b sx=%0d sy=%0d, want 1 0 0", clk_pixel, sx, sy);
        else passCount++;
        step();
        totalCount++;
        if ({clk_pixel, sx, sy} !== {1'b0, 10'd1, 10'd0})
            $display("[TB] FAIL mid_reset_edge2: got clk_pixel=%0b sx=%0d sy=%0d, want 0 1 0", clk_pixel, sx, sy);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_line_period();
        test_vertical_active();
        test_vsync();
        test_frame_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
